dcache_responder: RTL and testbench

- Data-side memory responder serving the MEM pipeline stage. It is the slave end of the MemRead/MemWrite/Mready handshake that the hazard unit uses to stall the pipeline.
- Direct-mapped, write-through, no-write-allocate cache in front of a multi-cycle backing memory with a req/ack word interface.
- Read hits complete in the same cycle. Misses and all writes stall the core until Mready_o.

---
 rtl/dcache_responder.sv | 149 ++++++++++++++
 tb/tb_dcache_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// Direct-mapped write-through, no-write-allocate data cache answering the MEM-stage MemRead/MemWrite/Mready handshake.
// Read hit: same cycle. Read miss: LINE_WORDS x memory latency + 1. Write: memory latency + 1.
// The core stalls while Mready_o=0. The backing memory paces every beat and write with its one-cycle MemAck_i.
//
// Ports: clk_i/rst_n_i (async active-low), core side MemRead_i/MemWrite_i/Addr_i/WData_i -> RData_o/Mready_o,
//        memory side MemReq_o/MemWe_o/MemAddr_o/MemWData_o <- MemAck_i/MemRData_i.
// Optional: define DCACHE_STATS_EN to add HitCnt_o/MissCnt_o (read hits / refills, wrap at 2^32).
module dcache_responder #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] Addr_i,
  input  logic [31:0]       WData_i,
  output logic [31:0]       RData_o,
  output logic              Mready_o,
  output logic              MemReq_o,
  output logic              MemWe_o,
  output logic [ADDR_W-1:0] MemAddr_o,
  output logic [31:0]       MemWData_o,
  input  logic              MemAck_i,
  input  logic [31:0]       MemRData_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       HitCnt_o,
  output logic [31:0]       MissCnt_o
`endif
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int IDX_LO = OFF_W + 2;
  localparam int TAG_LO = IDX_LO + IDX_W;
  localparam int TAG_W  = ADDR_W - TAG_LO;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

  state_t            state_q;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       data_q [SETS][LINE_WORDS];
  logic [OFF_W-1:0]  beat_q;

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_tag;
  logic              hit;
  logic              rd_hit;
  logic              unused_addr;

  assign off = Addr_i[IDX_LO-1:2];
  assign idx = Addr_i[TAG_LO-1:IDX_LO];
  assign tag = Addr_i[ADDR_W-1:TAG_LO];
  assign unused_addr = ^Addr_i[1:0];

  // The line being refilled is taken from the outstanding memory address, so the
  // refill finishes on the right line even if the core withdraws its request.
  assign r_idx = MemAddr_o[TAG_LO-1:IDX_LO];
  assign r_tag = MemAddr_o[ADDR_W-1:TAG_LO];

  assign hit    = valid_q[idx] && (tag_q[idx] == tag);
  assign rd_hit = (state_q == IDLE) && !MemWrite_i && MemRead_i && hit;

  assign Mready_o = rd_hit || (state_q == WDONE);

  always_comb begin
    RData_o = '0;
    if (rd_hit) RData_o = data_q[idx][off];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      beat_q     <= '0;
      MemReq_o   <= 1'b0;
      MemWe_o    <= 1'b0;
      MemAddr_o  <= '0;
      MemWData_o <= '0;
`ifdef DCACHE_STATS_EN
      HitCnt_o   <= '0;
      MissCnt_o  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (MemWrite_i) begin
            state_q    <= WRITE;
            MemReq_o   <= 1'b1;
            MemWe_o    <= 1'b1;
            MemAddr_o  <= {Addr_i[ADDR_W-1:2], 2'b00};
            MemWData_o <= WData_i;
          end else if (MemRead_i && !hit) begin
            state_q      <= REFILL;
            valid_q[idx] <= 1'b0;  // a half-filled line must never hit
            beat_q       <= '0;
            MemReq_o     <= 1'b1;
            MemWe_o      <= 1'b0;
            MemAddr_o    <= {Addr_i[ADDR_W-1:IDX_LO], {OFF_W{1'b0}}, 2'b00};
`ifdef DCACHE_STATS_EN
            MissCnt_o    <= MissCnt_o + 32'd1;
`endif
          end
`ifdef DCACHE_STATS_EN
          if (rd_hit) HitCnt_o <= HitCnt_o + 32'd1;
`endif
        end
        REFILL: begin
          if (MemAck_i) begin
            if (beat_q == LAST_BEAT) begin
              state_q        <= IDLE;
              valid_q[r_idx] <= 1'b1;
              MemReq_o       <= 1'b0;
            end else begin
              beat_q                 <= beat_q + OFF_W'(1);
              MemAddr_o[IDX_LO-1:2]  <= beat_q + OFF_W'(1);
            end
          end
        end
        WRITE: begin
          if (MemAck_i) begin
            state_q  <= WDONE;
            MemReq_o <= 1'b0;
            MemWe_o  <= 1'b0;
          end
        end
        default: state_q <= IDLE;  // WDONE: the Mready_o pulse lasts exactly this one cycle
      endcase
    end
  end

  // Tag and data arrays need no reset: valid_q gates every use, and writes only
  // happen in REFILL/WRITE, which reset leaves immediately.
  always_ff @(posedge clk_i) begin
    if (state_q == REFILL && MemAck_i) begin
      data_q[r_idx][beat_q] <= MemRData_i;
      if (beat_q == LAST_BEAT) tag_q[r_idx] <= r_tag;
    end
    if (state_q == WRITE && MemAck_i && hit) data_q[idx][off] <= WData_i;
  end

endmodule

// File: tb/tb_dcache_responder.sv
module tb_dcache_responder;
  localparam int SETS = 16;
  localparam int LW   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [31:0] Addr, WData;
  logic [31:0] RData;
  logic        Mready, MemReq, MemWe;
  logic [31:0] MemAddr, MemWData;
  logic        MemAck;
  logic [31:0] MemRData;
`ifdef DCACHE_STATS_EN
  logic [31:0] HitCnt, MissCnt;
`endif

  dcache_responder #(.SETS(SETS), .LINE_WORDS(LW), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .MemRead_i(MemRead), .MemWrite_i(MemWrite),
    .Addr_i(Addr), .WData_i(WData), .RData_o(RData), .Mready_o(Mready),
    .MemReq_o(MemReq), .MemWe_o(MemWe), .MemAddr_o(MemAddr), .MemWData_o(MemWData),
    .MemAck_i(MemAck), .MemRData_i(MemRData)
`ifdef DCACHE_STATS_EN
    , .HitCnt_o(HitCnt), .MissCnt_o(MissCnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- backing memory model ----------------
  // Acks on the lat-th consecutive cycle that MemReq is seen high; every access is logged.
  typedef struct { bit we; bit [31:0] addr; bit [31:0] data; } acc_t;
  acc_t          acc_log[$];
  bit [31:0]     mem     [bit [31:0]];
  bit [31:0]     preload [bit [31:0]];
  int            lat = 2;
  int            mcnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      mcnt = 0; MemAck = 1'b0; MemRData = '0;
    end else if (MemReq) begin
      mcnt++;
      if (mcnt >= lat) begin
        mcnt = 0;
        MemAck = 1'b1;
        if (MemWe) begin
          mem[MemAddr] = MemWData;
          acc_log.push_back('{1'b1, MemAddr, MemWData});
        end else begin
          if (!mem.exists(MemAddr)) mem[MemAddr] = preload.exists(MemAddr) ? preload[MemAddr] : $urandom;
          MemRData = mem[MemAddr];
          acc_log.push_back('{1'b0, MemAddr, mem[MemAddr]});
        end
      end else MemAck = 1'b0;
    end else begin
      mcnt = 0; MemAck = 1'b0;
    end
  end

  // ---------------- cache reference model ----------------
  bit          mvalid [SETS];
  int unsigned mtag   [SETS];
  int          exp_hits = 0;
  int          exp_miss = 0;

  function automatic int unsigned idx_of(bit [31:0] a);
    return (a / (4 * LW)) % SETS;
  endfunction
  function automatic int unsigned tag_of(bit [31:0] a);
    return a / (4 * LW * SETS);
  endfunction
  function automatic void model_reset();
    for (int i = 0; i < SETS; i++) mvalid[i] = 1'b0;
    exp_hits = 0; exp_miss = 0;
  endfunction
  function automatic void model_install(bit [31:0] a);
    mvalid[idx_of(a)] = 1'b1;
    mtag[idx_of(a)]   = tag_of(a);
  endfunction
  function automatic bit model_hit(bit [31:0] a);
    return mvalid[idx_of(a)] && (mtag[idx_of(a)] == tag_of(a));
  endfunction

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  // One core access; starts and ends 1 time unit after a rising edge.
  task automatic op(input bit wr, input bit rd, input bit [31:0] a, input bit [31:0] wd, input string nm);
    bit          is_hit, got;
    int          exp_lat, n;
    logic [31:0] rdat;
    bit [31:0]   ka, base;
    ka     = a & ~32'h3;
    base   = a - (a % (4 * LW));
    is_hit = model_hit(a);
    if (wr)          exp_lat = lat + 1;
    else if (is_hit) exp_lat = 0;
    else             exp_lat = LW * lat + 1;
    acc_log.delete();
    MemWrite = wr; MemRead = rd; Addr = a; WData = wd;
    n = 0; got = 1'b0; rdat = 'x;
    while (n < 200) begin
      @(negedge clk);
      if (Mready) begin
        got  = 1'b1;
        rdat = RData;
        if (!wr && is_hit) chk({nm, " req_on_hit"}, {31'd0, MemReq}, 32'd0);
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " completed"}, {31'd0, got}, 32'd1);
    chk({nm, " latency"}, n, exp_lat);
    if (wr) chk({nm, " rdata_on_write"}, rdat, 32'd0);
    else    chk({nm, " rdata"}, rdat, mem.exists(ka) ? mem[ka] : 32'hxxxxxxxx);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    if (wr) begin
      chk({nm, " mem_accesses"}, acc_log.size(), 1);
      if (acc_log.size() == 1) begin
        chk({nm, " mem_we"},    {31'd0, acc_log[0].we}, 32'd1);
        chk({nm, " mem_addr"},  acc_log[0].addr, ka);
        chk({nm, " mem_wdata"}, acc_log[0].data, wd);
      end
    end else if (is_hit) begin
      chk({nm, " mem_accesses"}, acc_log.size(), 0);
      exp_hits++;
    end else begin
      chk({nm, " mem_accesses"}, acc_log.size(), LW);
      foreach (acc_log[k]) begin
        chk({nm, " beat_addr"}, acc_log[k].addr, base + 32'(4 * k));
        chk({nm, " beat_we"},   {31'd0, acc_log[k].we}, 32'd0);
      end
      model_install(a);
      exp_miss++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    bit          mr_seen;
    bit [31:0]   a, d;

    for (int k = 0; k < LW; k++) preload[32'h40 + 32'(4 * k)] = 32'hA0 + 32'(k);

    // reset state
    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Addr = '0; WData = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst Mready", {31'd0, Mready}, 32'd0);
    chk("rst MemReq", {31'd0, MemReq}, 32'd0);
    chk("rst MemWe",  {31'd0, MemWe},  32'd0);
    chk("rst RData",  RData,    32'd0);
    chk("rst MemAddr", MemAddr, 32'd0);
    chk("rst MemWData", MemWData, 32'd0);
`ifdef DCACHE_STATS_EN
    chk("rst HitCnt", HitCnt, 32'd0);
    chk("rst MissCnt", MissCnt, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed: cold miss, hit, write hit, write miss (no allocate), read+write together
    lat = 2; op(1'b0, 1'b1, 32'h40, 32'h0, "cold_rd_40");
    op(1'b0, 1'b1, 32'h48, 32'h0, "hit_rd_48");
    lat = 3; op(1'b1, 1'b0, 32'h44, 32'hDEADBEEF, "wr_hit_44");
    op(1'b0, 1'b1, 32'h44, 32'h0, "rd_after_wr_44");
    lat = 2; op(1'b1, 1'b0, 32'h400, 32'h1234, "wr_miss_400");
    op(1'b0, 1'b1, 32'h400, 32'h0, "rd_miss_400");
    op(1'b1, 1'b1, 32'h48, 32'h5A5A0048, "rd_wr_both_48");
    op(1'b0, 1'b1, 32'h48, 32'h0, "rd_after_both_48");

    // random mix over a few conflicting tags and sets
    for (int i = 0; i < 40; i++) begin
      lat = $urandom_range(1, 3);
      a = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
      d = $urandom;
      case ($urandom_range(0, 3))
        0, 1: op(1'b0, 1'b1, a, d, "rnd_rd");
        2:    op(1'b1, 1'b0, a, d, "rnd_wr");
        default: op(1'b1, 1'b1, a, d, "rnd_both");
      endcase
    end

    // reset while beat 2 of a refill is outstanding
    lat = 2; acc_log.delete();
    MemRead = 1'b1; Addr = 32'h800;
    n = 0;
    while (acc_log.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
    chk("rst_mid beats_done", acc_log.size(), 2);
    chk("rst_mid beat2 addr", MemAddr, 32'h808);
    chk("rst_mid req_before", {31'd0, MemReq}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid req_after", {31'd0, MemReq}, 32'd0);
    chk("rst_mid mready", {31'd0, Mready}, 32'd0);
    MemRead = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    op(1'b0, 1'b1, 32'h800, 32'h0, "rd_after_rst_800");
    op(1'b0, 1'b1, 32'h800, 32'h0, "hit1_800");
    op(1'b0, 1'b1, 32'h804, 32'h0, "hit2_804");
    op(1'b0, 1'b1, 32'h808, 32'h0, "hit3_808");
`ifdef DCACHE_STATS_EN
    chk("stats HitCnt", HitCnt, exp_hits);
    chk("stats MissCnt", MissCnt, exp_miss);
`endif
    op(1'b0, 1'b1, 32'h40, 32'h0, "rd_40_after_rst");

    // request withdrawn mid-refill: line still installed, no Mready pulse
    lat = 1; acc_log.delete();
    MemRead = 1'b1; Addr = 32'hC40;
    n = 0;
    while (acc_log.size() < 1 && n < 100) begin @(posedge clk); #1; n++; end
    MemRead = 1'b0;
    mr_seen = 1'b0;
    repeat (LW * lat + 3) begin
      @(negedge clk);
      if (Mready) mr_seen = 1'b1;
    end
    @(posedge clk); #1;
    chk("withdraw no_mready", {31'd0, mr_seen}, 32'd0);
    chk("withdraw beats", acc_log.size(), LW);
    model_install(32'hC40);
    exp_miss++;
    op(1'b0, 1'b1, 32'hC44, 32'h0, "withdraw_then_hit_C44");
`ifdef DCACHE_STATS_EN
    chk("stats2 HitCnt", HitCnt, exp_hits);
    chk("stats2 MissCnt", MissCnt, exp_miss);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
